// File: rtl/tile_plot_pkg.sv
// Shared types and constants for the tile plotter.
//   mode_e  : command modes (TILE, OUTLINE, CLEAR, reserved)
//   state_e : pixel engine states
//   cmd_t   : queued command record {mode, x, y, colour}
package tile_plot_pkg;
  localparam int VGA_XW = 8;
  localparam int VGA_YW = 7;
  // Coordinates are stored at a fixed width so the struct is parameter-free;
  // the top zero-extends its COORD_W inputs into it (COORD_W <= 8).
  localparam int CMD_CW = 8;

  typedef enum logic [1:0] {
    MODE_TILE    = 2'd0,
    MODE_OUTLINE = 2'd1,
    MODE_CLEAR   = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DRAW = 1'b1
  } state_e;

  typedef struct packed {
    mode_e             mode;
    logic [CMD_CW-1:0] x;
    logic [CMD_CW-1:0] y;
    logic [2:0]        colour;
  } cmd_t;
endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with full/empty flags and occupancy count.
//   push/din  : write when not full (or when popping in the same cycle)
//   pop/dout  : dout is the current head; pop discards it
//   full/empty/count : status from registered occupancy
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rp];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/tile_plot.sv
// Game-grid plotter: queues cell drawing commands and streams one pixel per
// clock to the VGA adapter's plot port.
//   cmd_*      : valid/ready command input {mode, x, y, colour}
//   busy       : work queued or being drawn
//   cmd_err    : one-cycle pulse for a discarded (invalid) command
//   vga_*      : registered pixel write strobe, coordinates and colour
module tile_plot import tile_plot_pkg::*; #(
  parameter int TILE       = 6,
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 16,
  parameter int COORD_W    = 4,
  parameter int X_OFF      = 32,
  parameter int Y_OFF      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [2:0]         cmd_colour,
  output logic               busy,
  output logic               cmd_err,
  output logic               vga_plot,
  output logic [VGA_XW-1:0]  vga_x,
  output logic [VGA_YW-1:0]  vga_y,
  output logic [2:0]         vga_colour
);
  cmd_t push_cmd, head;
  logic push, pop, full, empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  always_comb begin
    push_cmd        = '0;
    push_cmd.mode   = mode_e'(cmd_mode);
    push_cmd.x      = CMD_CW'(cmd_x);
    push_cmd.y      = CMD_CW'(cmd_y);
    push_cmd.colour = cmd_colour;
  end

  cmd_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(push), .din(push_cmd),
    .pop(pop), .dout(head),
    .full(full), .empty(empty), .count(fifo_cnt)
  );

  state_e     state, state_n;
  mode_e      cur_mode;
  logic [2:0] cur_col;
  logic [8:0] bx, by;          // pixel origin of the current scan
  logic [7:0] i, j, li, lj;    // scan counters and their last values
  logic       head_ok, load, err_n, err_pend, last_pix, plot_now;
  logic [8:0] ld_bx, ld_by;
  logic [7:0] ld_li, ld_lj;

  // CLEAR ignores the cell coordinates, so only the mode can reject it.
  assign head_ok = (head.mode == MODE_CLEAR) ||
                   ((head.mode != MODE_RSVD) &&
                    ({1'b0, head.x} < 9'(GRID_W)) &&
                    ({1'b0, head.y} < 9'(GRID_H)));

  assign last_pix = (i == li) && (j == lj);
  assign plot_now = (cur_mode != MODE_OUTLINE) ||
                    (i == 8'd0) || (j == 8'd0) || (i == li) || (j == lj);

  always_comb begin
    if (head.mode == MODE_CLEAR) begin
      ld_bx = 9'(X_OFF);
      ld_by = 9'(Y_OFF);
      ld_li = 8'(GRID_W*TILE-1);
      ld_lj = 8'(GRID_H*TILE-1);
    end else begin
      ld_bx = 9'(X_OFF) + 9'(head.x) * 9'(TILE);
      ld_by = 9'(Y_OFF) + 9'(head.y) * 9'(TILE);
      ld_li = 8'(TILE-1);
      ld_lj = 8'(TILE-1);
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    load    = 1'b0;
    err_n   = 1'b0;
    case (state)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        if (head_ok) begin
          load    = 1'b1;
          state_n = S_DRAW;
        end else begin
          err_n = 1'b1;
        end
      end
      S_DRAW: if (last_pix) begin
        // Chain straight into the next queued command with no idle cycle.
        if (!empty) begin
          pop = 1'b1;
          if (head_ok) begin
            load = 1'b1;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_mode   <= MODE_TILE;
      cur_col    <= '0;
      bx         <= '0;
      by         <= '0;
      i          <= '0;
      j          <= '0;
      li         <= '0;
      lj         <= '0;
      err_pend   <= 1'b0;
      cmd_err    <= 1'b0;
      busy       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      // Error pulse lines up with where a first pixel would have appeared.
      err_pend <= err_n;
      cmd_err  <= err_pend;
      // Registered view of the pipeline, so busy covers the final pixel.
      busy     <= push || (fifo_cnt != '0) || (state == S_DRAW);

      if (state == S_DRAW) begin
        vga_plot <= plot_now;
        if (plot_now) begin
          vga_x      <= VGA_XW'(bx + {1'b0, i});
          vga_y      <= VGA_YW'(by + {1'b0, j});
          vga_colour <= cur_col;
        end
        // y runs fastest, then x.
        if (!last_pix) begin
          if (j == lj) begin
            j <= '0;
            i <= i + 8'd1;
          end else begin
            j <= j + 8'd1;
          end
        end
      end else begin
        vga_plot <= 1'b0;
      end

      if (load) begin
        cur_mode <= head.mode;
        cur_col  <= head.colour;
        bx       <= ld_bx;
        by       <= ld_by;
        li       <= ld_li;
        lj       <= ld_lj;
        i        <= '0;
        j        <= '0;
      end
    end
  end
endmodule

// File: doc/tile_plot.md
# tile_plot

Parametrised successor to the single-tile game plotter: it converts game-grid drawing commands into per-pixel VGA framebuffer writes. Commands enter through a valid/ready handshake into a small command FIFO, so the game FSM can queue several cells without stalling. A pixel engine drains the FIFO, one pixel per clock, and supports three modes: solid tile, tile outline, and full-grid clear. It sits between the game logic and the VGA adapter's plot port.

## Interface
Parameters:
- TILE, 6, tile edge in pixels (2..15).
- GRID_W, 16, grid columns.
- GRID_H, 16, grid rows.
- COORD_W, 4, width of cell coordinates; must satisfy 2^COORD_W >= GRID_W, GRID_H.
- X_OFF, 32, pixel x of cell (0,0).
- Y_OFF, 12, pixel y of cell (0,0); X_OFF+GRID_W*TILE <= 160, Y_OFF+GRID_H*TILE <= 120.
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >= 2).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full; transfer on cmd_valid & cmd_ready at a rising edge.
- cmd_mode  in  2  0 TILE, 1 OUTLINE, 2 CLEAR, 3 reserved (rejected).
- cmd_x  in  COORD_W  cell column (ignored for CLEAR).
- cmd_y  in  COORD_W  cell row (ignored for CLEAR).
- cmd_colour  in  3  pixel colour.
- busy  out  1  FIFO non-empty or engine active.
- cmd_err  out  1  one-cycle pulse when an accepted command is rejected.
- vga_plot  out  1  pixel write strobe.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour.

## Operation
- The FIFO stores {mode, x, y, colour}. cmd_ready = !full. Push and pop are allowed in the same cycle when full.
- Engine states: IDLE, DRAW.
- IDLE: if the FIFO is non-empty, pop the head. A valid head loads counters and goes to DRAW. An invalid head (cmd_x >= GRID_W, cmd_y >= GRID_H, or mode 3) is discarded: cmd_err pulses for 1 cycle, no pixels are emitted, and the engine stays in IDLE.
- DRAW: scan order has y fastest, then x.
  - TILE: x = X_OFF + cmd_x*TILE + i, y = Y_OFF + cmd_y*TILE + j, with i, j in 0..TILE-1. Emits TILE² pixels.
  - OUTLINE: same scan, but vga_plot is asserted only where i or j is 0 or TILE-1. Interior cycles are still spent with vga_plot=0, so duration = TILE² cycles.
  - CLEAR: x from X_OFF to X_OFF+GRID_W*TILE-1, y from Y_OFF to Y_OFF+GRID_H*TILE-1. Emits every pixel.
- On the last pixel: if the FIFO is non-empty, pop it and start the next command on the following cycle with no gap. Otherwise go to IDLE.
- Arithmetic is carried out at 9 bits internally and truncated to 8/7 bits on output; parameter constraints guarantee no overflow.
- vga_x, vga_y and vga_colour hold their last values when vga_plot=0.

## Timing
- Reset values: state IDLE, FIFO empty, cmd_ready=1, busy=0, cmd_err=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- All outputs are registered.
- A command accepted at edge T with the engine idle and FIFO empty: busy=1 after T; the first pixel is on the outputs after edge T+2. TILE mode with TILE=6 places the last pixel after T+37, and busy=0 after T+38.
- Reset asserted mid-draw: outputs and FIFO clear immediately (asynchronously). Any queued command is lost.
- cmd_err asserts after the edge following the pop.

## Structure
- Package tile_plot_pkg holds the mode enum (MODE_TILE, MODE_OUTLINE, MODE_CLEAR, MODE_RSVD), the state enum, the packed cmd_t struct, and the VGA width constants (8/7).
- One sub-module: cmd_fifo, a parametrised synchronous FIFO with full/empty flags and count, instantiated with cmd_t width.

## Test plan
- Default params, TILE cmd (0,0,colour 000) -> 36 strobes, x 32..37 / y 12..17 with y fastest, busy drops one cycle after the last pixel.
- TILE (15,15,111) -> first pixel (122,102), last pixel (127,107), all strobes carry colour 111.
- OUTLINE (5,8,001) -> exactly 20 strobes, all on the border of x 62..67 / y 60..65, 36 cycles total.
- Push 5 commands back-to-back with FIFO_DEPTH=4 while the engine is busy -> cmd_ready low for the 5th until a pop. Commands draw with no idle cycle between them, in order.
- cmd_x=15 with GRID_W=12 (variant build) -> cmd_err pulse, zero strobes, following queued command still drawn.
- CLEAR colour 010, then rst_n low mid-scan -> 96×96 strobes stop immediately, outputs 0, cmd_ready=1, busy=0.
